// File: rtl/mem_access.sv
// ============================================================================
// Module   : mem_access
// Purpose  : MEM pipeline stage. Issues one data-memory access per load or
//            store, stalls the upstream pipeline until the memory acknowledges
//            or a wait timeout expires, and drives the MEM/WB register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // EX/MEM register
  input  logic        in_MemWrite,
  input  logic        in_MemRead,
  input  logic        in_MemtoReg,
  input  logic        in_RegWrite,
  input  logic        in_R31toReg,
  input  logic        in_JaltoReg,
  input  logic [31:0] in_RD2,
  input  logic [31:0] in_alu,
  input  logic [4:0]  in_mux,
  // data memory
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  // pipeline control / status
  output logic        stall,
  output logic        mem_err,
  // MEM/WB register
  output logic        out_RegWrite,
  output logic        out_MemtoReg,
  output logic        out_R31toReg,
  output logic        out_JaltoReg,
  output logic [4:0]  out_mux,
  output logic [31:0] out_alu,
  output logic [31:0] out_rdata
);

  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;

  logic w_idle;
  logic w_wait;
  logic w_access;
  logic w_illegal;
  logic w_start;
  logic w_timeout;
  logic w_abort;
  logic w_stall;

  assign w_idle    = (r_state == S_IDLE);
  assign w_wait    = (r_state == S_WAIT);
  assign w_access  = in_MemRead | in_MemWrite;
  assign w_illegal = (w_access & (in_alu[1:0] != 2'b00)) | (in_MemRead & in_MemWrite);
  assign w_start   = w_idle & w_access & ~w_illegal;
  assign w_timeout = w_wait & (r_cnt == c_timeout);
  // A late ack arriving in the timeout cycle still completes the access.
  assign w_abort   = w_timeout & ~dmem_ack;
  assign w_stall   = w_start | (w_wait & ~dmem_ack & ~w_timeout);

  assign stall      = w_stall;
  assign dmem_req   = w_wait & (r_cnt < c_timeout);
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign mem_err    = r_err;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: enter WAIT on a legal access, leave on ack or timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_WAIT;
      S_WAIT:  if (dmem_ack || w_timeout) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Wait counter: cleared on entry, counts un-acknowledged WAIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_cnt <= 8'd0;
    else if (w_start)                       r_cnt <= 8'd0;
    else if (w_wait && !dmem_ack && !w_timeout) r_cnt <= r_cnt + 8'd1;
  end

  // Request fields captured when the access is launched, held through WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_start) begin
      r_we    <= in_MemWrite;
      r_addr  <= {in_alu[31:2], 2'b00};
      r_wdata <= in_RD2;
    end
  end

  // Sticky error: misaligned/conflicting op or access timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_err <= 1'b0;
    else if ((w_idle && w_illegal) || w_abort) r_err <= 1'b1;
  end

  // MEM/WB register: bubble while stalled, otherwise load the finished op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_RegWrite <= 1'b0;
      out_MemtoReg <= 1'b0;
      out_R31toReg <= 1'b0;
      out_JaltoReg <= 1'b0;
      out_mux      <= 5'd0;
      out_alu      <= 32'd0;
      out_rdata    <= 32'd0;
    end else if (w_stall) begin
      out_RegWrite <= 1'b0;
      out_MemtoReg <= 1'b0;
      out_R31toReg <= 1'b0;
      out_JaltoReg <= 1'b0;
    end else if (w_idle) begin
      // Non-access op, or an illegal access that is squashed here.
      out_RegWrite <= in_RegWrite & ~w_illegal;
      out_MemtoReg <= in_MemtoReg & ~w_illegal;
      out_R31toReg <= in_R31toReg;
      out_JaltoReg <= in_JaltoReg;
      out_mux      <= in_mux;
      out_alu      <= in_alu;
      out_rdata    <= 32'd0;
    end else begin
      // WAIT and not stalled: ack or timeout this cycle.
      out_RegWrite <= in_RegWrite & ~w_abort;
      out_MemtoReg <= in_MemtoReg;
      out_R31toReg <= in_R31toReg;
      out_JaltoReg <= in_JaltoReg;
      out_mux      <= in_mux;
      out_alu      <= in_alu;
      out_rdata    <= (dmem_ack && !r_we) ? dmem_rdata : 32'd0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Self-checking bench for mem_access: directed vector table,
//            hand-written reset/illegal sequences and randomized operations
//            checked against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_MemWrite, in_MemRead, in_MemtoReg, in_RegWrite, in_R31toReg, in_JaltoReg;
  logic [31:0] in_RD2, in_alu;
  logic [4:0]  in_mux;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, mem_err;
  logic        out_RegWrite, out_MemtoReg, out_R31toReg, out_JaltoReg;
  logic [4:0]  out_mux;
  logic [31:0] out_alu, out_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // expected current MEM/WB data fields and error flag
  logic [4:0]  p_mux;
  logic [31:0] p_alu, p_rdata;
  logic        m_err;

  typedef struct {
    logic        wr, rd, m2r, rw, r31, jal;
    logic [31:0] rd2, alu, rdata;
    logic [4:0]  mux;
    int          dly;     // WAIT cycles before ack (large = never)
    bit          spur;    // ack pulse in the launch cycle (must be ignored)
    int          e_stall, e_req;
    logic        e_rw, e_m2r, e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_MemWrite(in_MemWrite), .in_MemRead(in_MemRead), .in_MemtoReg(in_MemtoReg),
    .in_RegWrite(in_RegWrite), .in_R31toReg(in_R31toReg), .in_JaltoReg(in_JaltoReg),
    .in_RD2(in_RD2), .in_alu(in_alu), .in_mux(in_mux),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .mem_err(mem_err),
    .out_RegWrite(out_RegWrite), .out_MemtoReg(out_MemtoReg), .out_R31toReg(out_R31toReg),
    .out_JaltoReg(out_JaltoReg), .out_mux(out_mux), .out_alu(out_alu), .out_rdata(out_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, rd, m2r, rw, r31, jal,
                              input logic [31:0] rd2, alu, rdata, input logic [4:0] mux,
                              input int dly, input bit spur);
    vec_t v;
    v.wr = wr; v.rd = rd; v.m2r = m2r; v.rw = rw; v.r31 = r31; v.jal = jal;
    v.rd2 = rd2; v.alu = alu; v.rdata = rdata; v.mux = mux; v.dly = dly; v.spur = spur;
    v.e_stall = 0; v.e_req = 0; v.e_rw = 0; v.e_m2r = 0; v.e_err = 0; v.e_rdata = 0;
    return v;
  endfunction

  // Transaction-level reference: outcome of one operation from its rules.
  function automatic vec_t model(input vec_t v, input logic err_in);
    vec_t r = v;
    bit acc = v.rd | v.wr;
    bit ill = (acc && v.alu[1:0] != 2'b00) || (v.rd && v.wr);
    r.e_err = err_in; r.e_rdata = 0; r.e_m2r = v.m2r; r.e_rw = v.rw;
    if (!acc) begin
      r.e_stall = 0; r.e_req = 0;
    end else if (ill) begin
      r.e_stall = 0; r.e_req = 0; r.e_rw = 0; r.e_m2r = 0; r.e_err = 1;
    end else if (v.dly <= TO) begin
      r.e_stall = 1 + v.dly;
      r.e_req   = (v.dly < TO) ? v.dly + 1 : TO;
      r.e_rdata = v.rd ? v.rdata : 32'd0;
    end else begin
      r.e_stall = 1 + TO; r.e_req = TO; r.e_rw = 0; r.e_err = 1;
    end
    return r;
  endfunction

  task automatic clear_inputs();
    in_MemWrite = 0; in_MemRead = 0; in_MemtoReg = 0; in_RegWrite = 0;
    in_R31toReg = 0; in_JaltoReg = 0; in_RD2 = 0; in_alu = 0; in_mux = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req"},  {63'd0, dmem_req}, 64'd0);
    chk({tag, "_req_fields"}, {31'd0, dmem_we, dmem_addr}, 64'd0);
    chk({tag, "_err"},  {63'd0, mem_err}, 64'd0);
    chk({tag, "_ctl"},  {60'd0, out_RegWrite, out_MemtoReg, out_R31toReg, out_JaltoReg}, 64'd0);
    chk({tag, "_data"}, {out_mux, out_alu, out_rdata[26:0]}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1;
    #1 check_reset_state("reset");
    @(negedge clk);
    rst = 0;
    p_mux = 0; p_alu = 0; p_rdata = 0; m_err = 0;
  endtask

  // Apply one op, watch every cycle until it completes, then check MEM/WB.
  task automatic do_op(input string name, input vec_t v);
    int  stalls = 0, reqs = 0;
    bit  req_ok = 1, bub_ok = 1, done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (k > 0 && !(out_RegWrite == 0 && out_MemtoReg == 0 && out_R31toReg == 0 &&
                     out_JaltoReg == 0 && out_mux == p_mux && out_alu == p_alu &&
                     out_rdata == p_rdata))
        bub_ok = 0;
      if (k == 0) begin
        in_MemWrite = v.wr; in_MemRead = v.rd; in_MemtoReg = v.m2r; in_RegWrite = v.rw;
        in_R31toReg = v.r31; in_JaltoReg = v.jal; in_RD2 = v.rd2; in_alu = v.alu;
        in_mux = v.mux; dmem_rdata = v.rdata;
      end
      dmem_ack = (k == v.dly + 1) || (k == 0 && v.spur);
      #1;
      if (dmem_req) begin
        reqs++;
        if (dmem_addr != {v.alu[31:2], 2'b00} || dmem_we != v.wr || dmem_wdata != v.rd2)
          req_ok = 0;
      end
      if (stall) stalls++;
      else done = 1;
    end
    chk({name, "_complete"}, {63'd0, done}, 64'd1);
    @(posedge clk);
    #1 dmem_ack = 0;
    chk({name, "_stall_cycles"}, 64'(stalls), 64'(v.e_stall));
    chk({name, "_req_cycles"},   64'(reqs),   64'(v.e_req));
    chk({name, "_req_fields"},   {63'd0, req_ok}, 64'd1);
    chk({name, "_bubbles"},      {63'd0, bub_ok}, 64'd1);
    chk({name, "_ctl"}, {60'd0, out_RegWrite, out_MemtoReg, out_R31toReg, out_JaltoReg},
        {60'd0, v.e_rw, v.e_m2r, v.r31, v.jal});
    chk({name, "_mux_alu"}, {27'd0, out_mux, out_alu}, {27'd0, v.mux, v.alu});
    chk({name, "_rdata"}, {32'd0, out_rdata}, {32'd0, v.e_rdata});
    chk({name, "_err"},   {63'd0, mem_err}, {63'd0, v.e_err});
    p_mux = v.mux; p_alu = v.alu; p_rdata = v.e_rdata; m_err = v.e_err;
  endtask

  initial begin
    vec_t v;
    rst = 1;
    clear_inputs();
    p_mux = 0; p_alu = 0; p_rdata = 0; m_err = 0;
    repeat (2) @(negedge clk);
    check_reset_state("init");
    chk("init_stall", {63'd0, stall}, 64'd0);
    rst = 0;

    // ---- directed table (TIMEOUT = 4) ----
    //              wr rd m2r rw r31 jal  rd2           alu           rdata         mux  dly spur
    tbl[0] = mk(0, 0, 0, 1, 0, 0, 32'h0,        32'h10,       32'h0,        5'd5,  0,  0);
    tbl[0].e_stall = 0; tbl[0].e_req = 0; tbl[0].e_rw = 1; tbl[0].e_m2r = 0; tbl[0].e_rdata = 32'h0;        tbl[0].e_err = 0;
    tbl[1] = mk(0, 1, 1, 1, 0, 0, 32'h0,        32'h100,      32'hDEADBEEF, 5'd3,  0,  1);
    tbl[1].e_stall = 1; tbl[1].e_req = 1; tbl[1].e_rw = 1; tbl[1].e_m2r = 1; tbl[1].e_rdata = 32'hDEADBEEF; tbl[1].e_err = 0;
    tbl[2] = mk(1, 0, 0, 0, 0, 0, 32'h12345678, 32'h44,       32'hAAAA5555, 5'd0,  3,  0);
    tbl[2].e_stall = 4; tbl[2].e_req = 4; tbl[2].e_rw = 0; tbl[2].e_m2r = 0; tbl[2].e_rdata = 32'h0;        tbl[2].e_err = 0;
    tbl[3] = mk(0, 1, 1, 1, 1, 0, 32'h0,        32'h2000,     32'hCAFEF00D, 5'd9,  4,  0);
    tbl[3].e_stall = 5; tbl[3].e_req = 4; tbl[3].e_rw = 1; tbl[3].e_m2r = 1; tbl[3].e_rdata = 32'hCAFEF00D; tbl[3].e_err = 0;
    tbl[4] = mk(0, 1, 1, 1, 0, 1, 32'h0,        32'h300,      32'h11111111, 5'd7, 99,  0);
    tbl[4].e_stall = 5; tbl[4].e_req = 4; tbl[4].e_rw = 0; tbl[4].e_m2r = 1; tbl[4].e_rdata = 32'h0;        tbl[4].e_err = 1;
    for (int i = 0; i < 5; i++) do_op($sformatf("tbl%0d", i), tbl[i]);

    // ---- misaligned read, then reset clears the sticky error ----
    do_reset();
    v = mk(0, 1, 1, 1, 0, 0, 32'h0, 32'h102, 32'h5, 5'd4, 0, 0);
    v.e_stall = 0; v.e_req = 0; v.e_rw = 0; v.e_m2r = 0; v.e_rdata = 0; v.e_err = 1;
    do_op("misaligned", v);
    v = mk(1, 1, 0, 1, 0, 0, 32'h9, 32'h200, 32'h5, 5'd6, 0, 0);
    v.e_stall = 0; v.e_req = 0; v.e_rw = 0; v.e_m2r = 0; v.e_rdata = 0; v.e_err = 1;
    do_op("rd_and_wr", v);
    do_reset();

    // ---- asynchronous reset in the middle of WAIT ----
    @(negedge clk);
    in_MemRead = 1; in_RegWrite = 1; in_alu = 32'h200; in_mux = 5'd2;
    @(negedge clk);
    @(negedge clk);
    #1 chk("midwait_req_before", {63'd0, dmem_req}, 64'd1);
    #1 rst = 1;
    #1 check_reset_state("midwait");
    clear_inputs();
    @(negedge clk);
    rst = 0;
    p_mux = 0; p_alu = 0; p_rdata = 0; m_err = 0;
    do_op("after_rst", model(mk(0, 1, 1, 1, 0, 0, 32'h0, 32'h204, 32'h600DF00D, 5'd8, 1, 0), m_err));

    // ---- randomized ops against the reference model ----
    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 0) do_reset();
      v = mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom, $urandom, $urandom, 5'($urandom), 0, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 99) < 85) v.alu[1:0] = 2'b00;
      if (v.rd && v.wr && $urandom_range(0, 1) == 1) v.rd = 0;
      v.dly = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 6));
      do_op($sformatf("rnd%0d", i), model(v, m_err));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
